// File: rtl/steered_beamformer_n.sv
// -----------------------------------------------------------------------------
// steered_beamformer_n
//   Two-microphone delay-and-sum direction finder. Each accepted L/R pair is
//   pushed into circular history buffers. One shared square-accumulate unit then
//   visits every steering angle, one angle per cycle. After WINDOW_SIZE pairs the
//   per-angle energies are scanned, one per cycle. The strongest angle is then
//   published with a one-cycle result_valid pulse.
//
//   Angle k uses delay d_k = (k - (NUM_ANGLES-1)/2) * DELAY_STEP.
//   When d < 0 the left channel is delayed by |d|. When d > 0 the right channel
//   is delayed by d.
//
// Ports
//   s_clk, rst      clock, synchronous active-high reset
//   sample_valid    L/R pair offered this cycle
//   sample_ready    block can take a pair (IDLE only)
//   l_sample        signed left sample
//   r_sample        signed right sample
//   result_valid    one-cycle pulse; best_* and dir_* were just updated
//   best_angle      winning angle index
//   best_energy     energy of the winning angle
//   dir_left        winning delay is negative
//   dir_right       winning delay is positive
//   overrun         sticky; a pair was offered while not ready
//
// Configuration macro
//   BEAMFORM_SAT_EN  when defined, the accumulators saturate at 2^ACC_W-1.
//                    Otherwise they wrap modulo 2^ACC_W.
// -----------------------------------------------------------------------------
module steered_beamformer_n #(
    parameter int unsigned SAMPLE_W    = 16,
    parameter int unsigned NUM_ANGLES  = 9,
    parameter int unsigned DELAY_STEP  = 3,
    parameter int unsigned MAX_DELAY   = 12,
    parameter int unsigned WINDOW_SIZE = 256,
    parameter int unsigned ACC_W       = 2 * SAMPLE_W + 2 + $clog2(WINDOW_SIZE)
) (
    input  logic                          s_clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic signed [SAMPLE_W-1:0]    l_sample,
    input  logic signed [SAMPLE_W-1:0]    r_sample,
    output logic                          result_valid,
    output logic [$clog2(NUM_ANGLES)-1:0] best_angle,
    output logic [ACC_W-1:0]              best_energy,
    output logic                          dir_left,
    output logic                          dir_right,
    output logic                          overrun
);

    localparam int unsigned DEPTH  = MAX_DELAY + 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned IDX_W  = $clog2(NUM_ANGLES);
    localparam int unsigned CNT_W  = $clog2(WINDOW_SIZE + 1);
    localparam int unsigned SUM_W  = SAMPLE_W + 1;
    localparam int unsigned SQ_W   = 2 * SAMPLE_W + 2;
    localparam int unsigned CENTER = (NUM_ANGLES - 1) / 2;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ANGLES - 1);
    localparam logic [IDX_W-1:0] CENTER_IDX = IDX_W'(CENTER);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_SCAN,
        S_OUT
    } state_t;

    // Control state
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;        // angle being accumulated or scanned
    logic [CNT_W-1:0] cnt_q, cnt_d;        // pairs accumulated in this window
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;  // next history slot to write
    logic [IDX_W-1:0] run_idx_q, run_idx_d;
    logic [ACC_W-1:0] run_e_q, run_e_d;

    // Storage
    logic signed [SAMPLE_W-1:0] hist_l_q [DEPTH];
    logic signed [SAMPLE_W-1:0] hist_r_q [DEPTH];
    logic        [ACC_W-1:0]    acc_q    [NUM_ANGLES];

    // Output registers
    logic             sample_ready_q;
    logic             result_valid_q;
    logic [IDX_W-1:0] best_angle_q;
    logic [ACC_W-1:0] best_energy_q;
    logic             dir_left_q;
    logic             dir_right_q;
    logic             overrun_q;

    // Datapath / control strobes
    logic                       accept;
    logic                       hist_we;
    logic                       acc_we;
    logic                       acc_clr;
    logic                       out_load;
    int unsigned                l_dly;
    int unsigned                r_dly;
    logic signed [SAMPLE_W-1:0] l_tap;
    logic signed [SAMPLE_W-1:0] r_tap;
    logic signed [SUM_W-1:0]    pair_sum;
    logic signed [SQ_W-1:0]     sq_s;
    logic        [SQ_W-1:0]     sq_u;
    logic        [ACC_W-1:0]    acc_next;

    assign accept = sample_valid && sample_ready_q;

    // Slot holding the sample 'dly' pairs older than the newest one.
    // The newest pair sits one slot behind wr_ptr.
    function automatic logic [PTR_W-1:0] tap_index(input logic [PTR_W-1:0] wp,
                                                   input int unsigned      dly);
        int unsigned pos;
        pos = 32'(wp) + DEPTH - 1 - dly;
        if (pos >= DEPTH) begin
            pos = pos - DEPTH;
        end
        return PTR_W'(pos);
    endfunction

    // Per-angle channel delays; only one side is ever delayed
    always_comb begin
        l_dly = 0;
        r_dly = 0;
        if (idx_q < CENTER_IDX) begin
            l_dly = (CENTER - 32'(idx_q)) * DELAY_STEP;
        end else begin
            r_dly = (32'(idx_q) - CENTER) * DELAY_STEP;
        end
    end

    assign l_tap    = hist_l_q[tap_index(wr_ptr_q, l_dly)];
    assign r_tap    = hist_r_q[tap_index(wr_ptr_q, r_dly)];
    assign pair_sum = SUM_W'(l_tap) + SUM_W'(r_tap);
    assign sq_s     = SQ_W'(pair_sum) * SQ_W'(pair_sum);
    assign sq_u     = $unsigned(sq_s);

    // Shared square-accumulate for the angle selected by idx_q
`ifdef BEAMFORM_SAT_EN
    localparam int unsigned ADD_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
    logic [ADD_W-1:0] add_full;

    assign add_full = ADD_W'(acc_q[idx_q]) + ADD_W'(sq_u);

    always_comb begin
        acc_next = add_full[ACC_W-1:0];
        if (|add_full[ADD_W-1:ACC_W]) begin
            acc_next = '1;
        end
    end
`else
    // Truncating the square before the add gives the same modulo-2^ACC_W result
    always_comb begin
        acc_next = acc_q[idx_q] + ACC_W'(sq_u);
    end
`endif

    // Next-state and control decode
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        run_idx_d = run_idx_q;
        run_e_d   = run_e_q;
        hist_we   = 1'b0;
        acc_we    = 1'b0;
        acc_clr   = 1'b0;
        out_load  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    hist_we  = 1'b1;
                    wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
                    idx_d    = '0;
                    state_d  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (32'(cnt_q) + 32'd1 == WINDOW_SIZE) ? S_SCAN : S_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_SCAN: begin
                // Strict compare keeps the lowest index on ties
                if (idx_q == '0 || acc_q[idx_q] > run_e_q) begin
                    run_e_d   = acc_q[idx_q];
                    run_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    out_load = 1'b1;
                    state_d  = S_OUT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_OUT: begin
                acc_clr = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge s_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            run_idx_q <= '0;
            run_e_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            run_idx_q <= run_idx_d;
            run_e_q   <= run_e_d;
        end
    end

    // History buffers and per-angle accumulators
    always_ff @(posedge s_clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                hist_l_q[i] <= '0;
                hist_r_q[i] <= '0;
            end
            for (int k = 0; k < int'(NUM_ANGLES); k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            if (hist_we) begin
                hist_l_q[wr_ptr_q] <= l_sample;
                hist_r_q[wr_ptr_q] <= r_sample;
            end
            if (acc_clr) begin
                for (int k = 0; k < int'(NUM_ANGLES); k++) begin
                    acc_q[k] <= '0;
                end
            end else if (acc_we) begin
                acc_q[idx_q] <= acc_next;
            end
        end
    end

    // Registered outputs; results load on the edge that enters OUT
    always_ff @(posedge s_clk) begin
        if (rst) begin
            sample_ready_q <= 1'b1;
            result_valid_q <= 1'b0;
            best_angle_q   <= '0;
            best_energy_q  <= '0;
            dir_left_q     <= 1'b0;
            dir_right_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            sample_ready_q <= (state_d == S_IDLE);
            result_valid_q <= out_load;
            if (sample_valid && !sample_ready_q) begin
                overrun_q <= 1'b1;
            end
            if (out_load) begin
                best_angle_q  <= run_idx_d;
                best_energy_q <= run_e_d;
                dir_left_q    <= (run_idx_d < CENTER_IDX);
                dir_right_q   <= (run_idx_d > CENTER_IDX);
            end
        end
    end

    assign sample_ready = sample_ready_q;
    assign result_valid = result_valid_q;
    assign best_angle   = best_angle_q;
    assign best_energy  = best_energy_q;
    assign dir_left     = dir_left_q;
    assign dir_right    = dir_right_q;
    assign overrun      = overrun_q;

endmodule
